// File: rtl/ram_sp_arb_if.sv
// ram_sp_arb_if: requester A/B handshake plus the RAM sys-side bus.
// slave modport = arbiter view, master modport = requesters + RAM view.
interface ram_sp_arb_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          v_a, v_b;
    logic          r_nw_a, r_nw_b;
    logic [AW-1:0] a_a, a_b;
    logic [DW-1:0] d_a, d_b;
    logic          rdy_a, rdy_b;
    logic          rv_a, rv_b;
    logic [DW-1:0] q_a, q_b;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_d;
    logic          ram_w;
    logic [DW-1:0] ram_q;
    logic          init_done;

    modport slave (
        input  v_a, v_b, r_nw_a, r_nw_b, a_a, a_b, d_a, d_b, ram_q,
        output rdy_a, rdy_b, rv_a, rv_b, q_a, q_b, ram_a, ram_d, ram_w, init_done
    );

    modport master (
        output v_a, v_b, r_nw_a, r_nw_b, a_a, a_b, d_a, d_b, ram_q,
        input  rdy_a, rdy_b, rv_a, rv_b, q_a, q_b, ram_a, ram_d, ram_w, init_done
    );
endinterface

// File: rtl/ram_sp_arb.sv
// ram_sp_arb: round-robin arbiter sharing one single-port RAM (1-cycle
// registered read) between requesters A and B. Commands are registered
// onto the RAM bus; read data returns 2 cycles after accept, tagged to
// its owner. Define RAM_ARB_INIT_EN to zero-fill the RAM after reset
// before any request is granted.
module ram_sp_arb #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic clk,
    input  logic rst,
    ram_sp_arb_if.slave bus
);
    typedef enum logic {S_INIT, S_RUN} state_t;

    // rd: command was an accepted read; own: 0 = A, 1 = B
    typedef struct packed {
        logic rd;
        logic own;
    } tag_t;

    state_t        r_state, w_state_nxt;
    logic          r_prio;
    tag_t          r_tag0, r_tag1;
    logic [AW-1:0] r_ram_a;
    logic [DW-1:0] r_ram_d;
    logic          r_ram_w;
    logic [DW-1:0] r_q_a, r_q_b;

    logic          w_run, w_gnt_a, w_gnt_b, w_acc, w_rnw;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          w_rv_a, w_rv_b;

`ifdef RAM_ARB_INIT_EN
    localparam state_t RST_STATE = S_INIT;
    logic [AW-1:0] r_cnt;
    logic          w_sweep_last;
    assign w_sweep_last = (r_cnt == {AW{1'b1}});

    // Sweep address counter, only advances while zero-filling
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  r_cnt <= '0;
        else if (r_state == S_INIT) r_cnt <= r_cnt + 1'b1;
    end
`else
    localparam state_t RST_STATE = S_RUN;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= RST_STATE;
        else      r_state <= w_state_nxt;
    end

    // Next state: INIT leaves after the last sweep address is issued
    always_comb begin
        w_state_nxt = r_state;
`ifdef RAM_ARB_INIT_EN
        if (r_state == S_INIT && w_sweep_last) w_state_nxt = S_RUN;
`endif
    end

    // Grant: lone requester wins, contested grant goes to prio
    assign w_run   = (r_state == S_RUN) && rst;
    assign w_gnt_a = w_run && bus.v_a && (!bus.v_b || !r_prio);
    assign w_gnt_b = w_run && bus.v_b && (!bus.v_a ||  r_prio);
    assign w_acc   = w_gnt_a || w_gnt_b;
    assign w_rnw   = w_gnt_b ? bus.r_nw_b : bus.r_nw_a;
    assign w_addr  = w_gnt_b ? bus.a_b    : bus.a_a;
    assign w_data  = w_gnt_b ? bus.d_b    : bus.d_a;

    // Priority flips to the loser after each contested grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                           r_prio <= 1'b0;
        else if (w_run && bus.v_a && bus.v_b) r_prio <= ~r_prio;
    end

    // Command stage driving the RAM; address/data hold when idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ram_a <= '0;
            r_ram_d <= '0;
            r_ram_w <= 1'b0;
        end else
`ifdef RAM_ARB_INIT_EN
        if (r_state == S_INIT) begin
            r_ram_a <= r_cnt;
            r_ram_d <= '0;
            r_ram_w <= 1'b1;
        end else
`endif
        if (w_acc) begin
            r_ram_a <= w_addr;
            r_ram_d <= w_data;
            r_ram_w <= ~w_rnw;
        end else begin
            r_ram_w <= 1'b0;
        end
    end

    // Tag pipe: stage 0 aligns with the RAM command, stage 1 with ram_q
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag0 <= '0;
            r_tag1 <= '0;
        end else begin
            r_tag0 <= {w_acc && w_rnw, w_gnt_b};
            r_tag1 <= r_tag0;
        end
    end

    assign w_rv_a = r_tag1.rd && !r_tag1.own;
    assign w_rv_b = r_tag1.rd &&  r_tag1.own;

    // Hold the last returned word per requester between strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q_a <= '0;
            r_q_b <= '0;
        end else begin
            if (w_rv_a) r_q_a <= bus.ram_q;
            if (w_rv_b) r_q_b <= bus.ram_q;
        end
    end

    assign bus.rdy_a     = w_gnt_a;
    assign bus.rdy_b     = w_gnt_b;
    assign bus.rv_a      = w_rv_a;
    assign bus.rv_b      = w_rv_b;
    assign bus.q_a       = w_rv_a ? bus.ram_q : r_q_a;
    assign bus.q_b       = w_rv_b ? bus.ram_q : r_q_b;
    assign bus.ram_a     = r_ram_a;
    assign bus.ram_d     = r_ram_d;
    assign bus.ram_w     = r_ram_w;
    assign bus.init_done = w_run;
endmodule

// File: tb/tb_ram_sp_arb.sv
// tb_ram_sp_arb: table-driven cycle vectors with expected grants, a
// behavioural single-port RAM, and a read-data scoreboard fed by a
// shadow memory. Handles both builds of RAM_ARB_INIT_EN.
module tb_ram_sp_arb;
    logic clk, rst;

    ram_sp_arb_if #(.AW(4), .DW(16)) bus ();

    ram_sp_arb #(.AW(4), .DW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ram_sp model: write-through echo on q; contents garbage (FFFF) in reset
    logic [15:0] mem [16];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'hFFFF;
        end else begin
            if (bus.ram_w) mem[bus.ram_a] <= bus.ram_d;
            bus.ram_q <= bus.ram_w ? bus.ram_d : mem[bus.ram_a];
        end
    end

    typedef struct {
        logic        own;
        logic [15:0] data;
        int          due;
    } exp_t;

    typedef struct {
        logic        va, rnwa;
        logic [3:0]  aa;
        logic [15:0] da;
        logic        vb, rnwb;
        logic [3:0]  ab;
        logic [15:0] db;
        logic        ra, rb;
    } row_t;

    exp_t        sbq [$];
    row_t        tbl [$];
    logic [15:0] shadow [16];
    int          n_chk, n_pass, cyc, wcnt, n_init;
    exp_t        e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic row_t mk(input logic va, input logic rnwa, input logic [3:0] aa,
                                input logic [15:0] da, input logic vb, input logic rnwb,
                                input logic [3:0] ab, input logic [15:0] db,
                                input logic ra, input logic rb);
        row_t r;
        r.va = va; r.rnwa = rnwa; r.aa = aa; r.da = da;
        r.vb = vb; r.rnwb = rnwb; r.ab = ab; r.db = db;
        r.ra = ra; r.rb = rb;
        return r;
    endfunction

    // Per-cycle scoreboard: compare due read returns, then log accepts
    task automatic mon();
        if (!rst) sbq.delete();
        if (bus.ram_w) wcnt++;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            if (!e.own) begin
                chk("rv_a", 32'(bus.rv_a), 32'd1);
                chk("rv_b_idle", 32'(bus.rv_b), 32'd0);
                chk("q_a", 32'(bus.q_a), 32'(e.data));
            end else begin
                chk("rv_b", 32'(bus.rv_b), 32'd1);
                chk("rv_a_idle", 32'(bus.rv_a), 32'd0);
                chk("q_b", 32'(bus.q_b), 32'(e.data));
            end
        end else if (bus.rv_a || bus.rv_b) begin
            chk("spurious_rv", 32'({bus.rv_a, bus.rv_b}), 32'd0);
        end
        if (bus.v_a && bus.rdy_a) begin
            if (bus.r_nw_a) sbq.push_back('{1'b0, shadow[bus.a_a], cyc + 2});
            else            shadow[bus.a_a] = bus.d_a;
        end
        if (bus.v_b && bus.rdy_b) begin
            if (bus.r_nw_b) sbq.push_back('{1'b1, shadow[bus.a_b], cyc + 2});
            else            shadow[bus.a_b] = bus.d_b;
        end
    endtask

    task automatic drive_slot();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        cyc++;
        mon();
    endtask

    task automatic apply(input row_t r);
        bus.v_a = r.va; bus.r_nw_a = r.rnwa; bus.a_a = r.aa; bus.d_a = r.da;
        bus.v_b = r.vb; bus.r_nw_b = r.rnwb; bus.a_b = r.ab; bus.d_b = r.db;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0; wcnt = 0; n_init = 0;
        for (int i = 0; i < 16; i++) shadow[i] = 16'hFFFF;
        rst = 1'b0;
        apply(mk(1, 1, 4'd1, 16'h0, 1, 1, 4'd2, 16'h0, 0, 0));

        // Reset state, with both requesters asking
        for (int i = 0; i < 2; i++) begin
            drive_slot();
            sample();
            chk("rst_rdy_a", 32'(bus.rdy_a), 32'd0);
            chk("rst_rdy_b", 32'(bus.rdy_b), 32'd0);
            chk("rst_ram_w", 32'(bus.ram_w), 32'd0);
            chk("rst_init_done", 32'(bus.init_done), 32'd0);
        end
        chk("rst_ram_a", 32'(bus.ram_a), 32'd0);
        chk("rst_ram_d", 32'(bus.ram_d), 32'd0);
        chk("rst_q_a", 32'(bus.q_a), 32'd0);
        chk("rst_q_b", 32'(bus.q_b), 32'd0);

        drive_slot();
        rst = 1'b1;
        apply(mk(0, 1, 4'd0, 16'h0, 0, 1, 4'd0, 16'h0, 0, 0));
        sample();
`ifdef RAM_ARB_INIT_EN
        wcnt   = 0;
        n_init = 1;
        while (!bus.init_done && n_init < 40) begin
            drive_slot();
            sample();
            chk("init_rdy_a", 32'(bus.rdy_a), 32'd0);
            n_init++;
        end
        chk("init_done_cycle", 32'(n_init), 32'd17);
        chk("init_writes", 32'(wcnt), 32'd16);
        for (int i = 0; i < 16; i++) shadow[i] = 16'h0000;
`else
        chk("init_done_after_rst", 32'(bus.init_done), 32'd1);
`endif

        // Cycle table: {A req, B req, expected rdy_a, rdy_b}
        tbl.push_back(mk(1, 0, 4'd3, 16'h1234, 0, 0, 4'd0, 16'h0,    1, 0));
        tbl.push_back(mk(1, 1, 4'd3, 16'h0,    0, 0, 4'd0, 16'h0,    1, 0));
        tbl.push_back(mk(0, 0, 4'd0, 16'h0,    0, 0, 4'd0, 16'h0,    0, 0));
        tbl.push_back(mk(0, 0, 4'd0, 16'h0,    0, 0, 4'd0, 16'h0,    0, 0));
        tbl.push_back(mk(0, 0, 4'd0, 16'h0,    1, 0, 4'd7, 16'hBEEF, 0, 1));
        tbl.push_back(mk(1, 1, 4'd7, 16'h0,    0, 0, 4'd0, 16'h0,    1, 0));
        tbl.push_back(mk(1, 0, 4'd5, 16'h5555, 0, 0, 4'd0, 16'h0,    1, 0));
        tbl.push_back(mk(0, 0, 4'd0, 16'h0,    1, 0, 4'd9, 16'h9999, 0, 1));
        tbl.push_back(mk(1, 1, 4'd5, 16'h0,    1, 1, 4'd9, 16'h0,    1, 0));
        tbl.push_back(mk(1, 1, 4'd5, 16'h0,    1, 1, 4'd9, 16'h0,    0, 1));
        tbl.push_back(mk(1, 1, 4'd5, 16'h0,    1, 1, 4'd9, 16'h0,    1, 0));
        tbl.push_back(mk(1, 1, 4'd5, 16'h0,    1, 1, 4'd9, 16'h0,    0, 1));
        tbl.push_back(mk(1, 1, 4'd15, 16'h0,   0, 0, 4'd0, 16'h0,    1, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 0, 4'(i), 16'hA000 + 16'(i), 0, 0, 4'd0, 16'h0, 1, 0));
        tbl.push_back(mk(1, 1, 4'd4, 16'h0,    0, 0, 4'd0, 16'h0,    1, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 0, 4'd0, 16'h0, 0, 0, 4'd0, 16'h0, 0, 0));

        wcnt = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            drive_slot();
            apply(tbl[i]);
            sample();
            chk($sformatf("rdy_a[%0d]", i), 32'(bus.rdy_a), 32'(tbl[i].ra));
            chk($sformatf("rdy_b[%0d]", i), 32'(bus.rdy_b), 32'(tbl[i].rb));
        end
        chk("write_strobes", 32'(wcnt), 32'd9);
        chk("reads_drained", 32'(sbq.size()), 32'd0);

        // Reset one cycle after a read accept: read must never return
        drive_slot();
        apply(mk(1, 1, 4'd3, 16'h0, 0, 0, 4'd0, 16'h0, 0, 0));
        sample();
        chk("pre_rst_rdy_a", 32'(bus.rdy_a), 32'd1);
        drive_slot();
        rst = 1'b0;
        sample();
        chk("midrst_rdy_a", 32'(bus.rdy_a), 32'd0);
        chk("midrst_ram_a", 32'(bus.ram_a), 32'd0);
        chk("midrst_ram_d", 32'(bus.ram_d), 32'd0);
        chk("midrst_ram_w", 32'(bus.ram_w), 32'd0);
        chk("midrst_q_a", 32'(bus.q_a), 32'd0);
        chk("midrst_q_b", 32'(bus.q_b), 32'd0);
        chk("midrst_rv", 32'({bus.rv_a, bus.rv_b}), 32'd0);
        drive_slot();
        rst = 1'b1;
        apply(mk(0, 1, 4'd0, 16'h0, 0, 1, 4'd0, 16'h0, 0, 0));
        sample();
        for (int i = 0; i < 3; i++) begin
            drive_slot();
            sample();
            chk("post_rst_rv", 32'({bus.rv_a, bus.rv_b}), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
